// File: rtl/zxbus_arb_pkg.sv
// rtl/zxbus_arb_pkg.sv - shared types, defaults and helpers for the Z80 bus arbiter
//
// Holds the FSM state encoding, the default parameter values and a constant
// clog2 helper for sizing counters.
package zxbus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        HOLDOFF = 3'd4
    } arb_state_t;

    localparam int N_DEF           = 4;
    localparam int IDW_DEF         = 2;
    localparam int MIN_CPU_CYC_DEF = 8;
    localparam int TIMEOUT_CYC_DEF = 1024;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/z80_bus_arbiter_rr_picker.sv
// rtl/z80_bus_arbiter_rr_picker.sv - combinational round-robin requester picker
//
// Ports:
//   req_i    : request vector
//   ptr_i    : search start index (0..N-1)
//   any_o    : at least one request is set
//   winner_o : first set request at or after ptr_i, wrapping modulo N
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           any_o,
    output logic [IDW-1:0] winner_o
);

    // Rotate so that bit 0 corresponds to the requester at ptr_i.
    logic [N-1:0] rot_w;
    assign rot_w = N'({req_i, req_i} >> ptr_i);

    logic [IDW:0] idx_w;

    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx_w    = '0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && rot_w[i]) begin
                any_o = 1'b1;
                idx_w = {1'b0, ptr_i} + (IDW+1)'(i);
                if (idx_w >= (IDW+1)'(N)) begin
                    idx_w = idx_w - (IDW+1)'(N);
                end
                winner_o = idx_w[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - BUSRQ_n/BUSAK_n arbiter sharing the T80 bus with N masters
//
// Optional feature macro: BUSARB_TIMEOUT_EN (grant-length timeout with
// per-requester re-request mask).
//
// Ports:
//   clk         : system clock (CPU core clock)
//   reset       : asynchronous active-high reset
//   cpu_busrq_n : registered BUSRQ_n to the CPU
//   cpu_busak_n : BUSAK_n from the CPU, same clock domain
//   req         : per-requester level requests
//   gnt         : registered one-hot grant
//   bus_own     : high while a requester owns the bus (top-level mux select)
//   owner       : index of the current or last grantee
//   timeout_evt : one-cycle pulse when a grant is revoked by timeout
module z80_bus_arbiter
    import zxbus_arb_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int IDW         = IDW_DEF,
    parameter int MIN_CPU_CYC = MIN_CPU_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    output logic           cpu_busrq_n,
    input  logic           cpu_busak_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           bus_own,
    output logic [IDW-1:0] owner,
    output logic           timeout_evt
);

    localparam int HCW = (clog2(MIN_CPU_CYC + 1) < 1) ? 1 : clog2(MIN_CPU_CYC + 1);

    arb_state_t     state_q, state_d;
    logic           busrq_q, busrq_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           own_q, own_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;

    logic [N-1:0]   req_eff;
    logic           pick_any;
    logic [IDW-1:0] pick_w;
    logic [IDW:0]   ptr_nxt;
    logic           owner_req;
    logic           grant_now;
    logic           abort_now;
    logic           revoke_now;
    logic           tmo_now;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req_i    (req_eff),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_w)
    );

    // gnt_q is one-hot in GRANT, so this is req[owner].
    assign owner_req  = |(req & gnt_q);

    // An abort (all requests gone) takes priority over a same-cycle acknowledge.
    assign abort_now  = (state_q == REQ) && !pick_any;
    assign grant_now  = (state_q == REQ) && pick_any && !cpu_busak_n;
    // BUSAK_n rising during a grant means the CPU was reset: revoke.
    assign revoke_now = (state_q == GRANT) && (!owner_req || cpu_busak_n);

    always_comb begin
        ptr_nxt = {1'b0, pick_w} + (IDW+1)'(1);
        if (ptr_nxt >= (IDW+1)'(N)) begin
            ptr_nxt = '0;
        end
    end

`ifdef BUSARB_TIMEOUT_EN
    localparam int TW = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);

    logic [TW-1:0] tcnt_q;
    logic [N-1:0]  mask_q;
    logic          tevt_q;

    assign tmo_now     = (state_q == GRANT) && !revoke_now &&
                         (tcnt_q == TW'(TIMEOUT_CYC - 1));
    // A timed-out requester stays masked until its request is seen low.
    assign req_eff     = req & ~mask_q;
    assign timeout_evt = tevt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            mask_q <= '0;
            tevt_q <= 1'b0;
        end else begin
            tevt_q <= tmo_now;
            mask_q <= (mask_q & req) | (tmo_now ? gnt_q : '0);
            if (grant_now) begin
                tcnt_q <= '0;
            end else if (state_q == GRANT) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC != 0);
    assign tmo_now        = 1'b0;
    assign req_eff        = req;
    assign timeout_evt    = 1'b0;
`endif

    // State register (all outputs are registered here too).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busrq_q <= 1'b1;
            gnt_q   <= '0;
            own_q   <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            busrq_q <= busrq_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req_eff) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (abort_now) begin
                    state_d = RELEASE;
                end else if (grant_now) begin
                    state_d = GRANT;
                    ptr_d   = ptr_nxt[IDW-1:0];
                end
            end
            GRANT: begin
                if (revoke_now || tmo_now) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (cpu_busak_n) begin
                    if (MIN_CPU_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        hold_d  = HCW'(MIN_CPU_CYC);
                    end
                end
            end
            HOLDOFF: begin
                hold_d = (hold_q != '0) ? hold_q - HCW'(1) : '0;
                if (hold_q <= HCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values.
    always_comb begin
        busrq_d = busrq_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                busrq_d = !(|req_eff);
                gnt_d   = '0;
                own_d   = 1'b0;
            end
            REQ: begin
                busrq_d = abort_now;
                if (grant_now) begin
                    gnt_d   = N'(1) << pick_w;
                    own_d   = 1'b1;
                    owner_d = pick_w;
                end
            end
            GRANT: begin
                if (revoke_now || tmo_now) begin
                    gnt_d   = '0;
                    own_d   = 1'b0;
                    busrq_d = 1'b1;
                end
            end
            default: begin
                busrq_d = 1'b1;
                gnt_d   = '0;
                own_d   = 1'b0;
            end
        endcase
    end

    assign cpu_busrq_n = busrq_q;
    assign gnt         = gnt_q;
    assign bus_own     = own_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - self-checking bench for z80_bus_arbiter
module tb_z80_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       busrq_n, busak_n;
    logic [3:0] req, gnt;
    logic       own, tevt;
    logic [1:0] owner;

    logic       busrq0_n, busak0_n;
    logic [3:0] req0, gnt0;
    logic       own0, tevt0;
    logic [1:0] owner0;

    int checks   = 0;
    int failures = 0;

    bit cpu_auto = 1'b0;
    int lo_cnt   = 0;
    int hi_cnt   = 0;
    localparam int AK_DLY = 3;

    z80_bus_arbiter #(
        .N (4), .IDW (2), .MIN_CPU_CYC (8), .TIMEOUT_CYC (16)
    ) u_dut (
        .clk (clk), .reset (reset), .cpu_busrq_n (busrq_n), .cpu_busak_n (busak_n),
        .req (req), .gnt (gnt), .bus_own (own), .owner (owner), .timeout_evt (tevt)
    );

    z80_bus_arbiter #(
        .N (4), .IDW (2), .MIN_CPU_CYC (0), .TIMEOUT_CYC (1024)
    ) u_dut0 (
        .clk (clk), .reset (reset), .cpu_busrq_n (busrq0_n), .cpu_busak_n (busak0_n),
        .req (req0), .gnt (gnt0), .bus_own (own0), .owner (owner0), .timeout_evt (tevt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0] req;
        logic       ak;
        logic       rq;
        logic [3:0] gnt;
        logic       own;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock; then a simple CPU model answers busrq_n after AK_DLY cycles
    // and releases busak_n one cycle after busrq_n returns high.
    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_auto) begin
            if (!busrq_n) begin
                hi_cnt = 0;
                if (busak_n) begin
                    lo_cnt++;
                    if (lo_cnt >= AK_DLY) busak_n = 1'b0;
                end
            end else begin
                lo_cnt = 0;
                if (!busak_n) begin
                    hi_cnt++;
                    if (hi_cnt >= 1) busak_n = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        cpu_auto = 1'b0;
        req      = '0;
        req0     = '0;
        busak_n  = 1'b1;
        busak0_n = 1'b1;
        lo_cnt   = 0;
        hi_cnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input int limit);
        int t;
        t = 0;
        while (gnt == 4'd0 && t < limit) begin
            step();
            t++;
        end
    endtask

    initial begin
        int exp_order [0:5];
        int n;
        int tev;
        int regrant;

        exp_order = '{0, 1, 3, 0, 1, 3};

        //             req    ak    rq    gnt    own   owner
        tbl[0]  = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[2]  = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[3]  = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[4]  = '{4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0};
        tbl[5]  = '{4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0};
        tbl[6]  = '{4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0};
        tbl[7]  = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[8]  = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[9]  = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        for (int i = 10; i <= 17; i++) begin
            tbl[i] = '{4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        end
        tbl[18] = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[19] = '{4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0};
        tbl[20] = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[21] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};

        do_reset();
        chk("reset_busrq_n", busrq_n, 1);
        chk("reset_gnt", gnt, 0);
        chk("reset_bus_own", own, 0);
        chk("reset_owner", owner, 0);
        chk("reset_timeout_evt", tevt, 0);

        // Single request, acknowledge, release and holdoff.
        for (int i = 0; i <= 21; i++) begin
            req     = tbl[i].req;
            busak_n = tbl[i].ak;
            step();
            chk($sformatf("vec%0d_busrq_n", i), busrq_n, tbl[i].rq);
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("vec%0d_bus_own", i), own, tbl[i].own);
            chk($sformatf("vec%0d_owner", i), owner, tbl[i].owner);
            chk($sformatf("vec%0d_timeout_evt", i), tevt, 0);
        end

        // Round-robin order with requests 0,1,3 held.
        do_reset();
        cpu_auto = 1'b1;
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(100);
            chk($sformatf("rr%0d_gnt", k), gnt, 32'd1 << exp_order[k]);
            chk($sformatf("rr%0d_owner", k), owner, exp_order[k]);
            repeat (5) step();
            chk($sformatf("rr%0d_hold", k), gnt, 32'd1 << exp_order[k]);
            req[exp_order[k]] = 1'b0;
            n = 0;
            while (gnt != 4'd0 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("rr%0d_release", k), gnt, 0);
            step();
            req[exp_order[k]] = 1'b1;
        end

        // Abort before acknowledge; abort beats a same-cycle acknowledge.
        do_reset();
        req = 4'b0100;
        step();
        chk("abort_busrq_lo", busrq_n, 0);
        step();
        req = 4'b0000;
        busak_n = 1'b0;
        step();
        chk("abort_busrq_hi", busrq_n, 1);
        chk("abort_gnt", gnt, 0);
        chk("abort_bus_own", own, 0);
        req = 4'b0100;
        repeat (2) begin
            step();
            chk("abort_release_wait", busrq_n, 1);
            chk("abort_no_gnt", gnt, 0);
        end
        busak_n = 1'b1;
        step();
        for (int j = 1; j <= 8; j++) begin
            step();
            chk($sformatf("abort_holdoff%0d", j), busrq_n, 1);
        end
        step();
        chk("abort_rearm", busrq_n, 0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b0010;
        step();
        busak_n = 1'b0;
        step();
        chk("rst_pre_gnt", gnt, 4'b0010);
        #2;
        reset = 1'b1;
        busak_n = 1'b1;
        #1;
        chk("rst_async_gnt", gnt, 0);
        chk("rst_async_bus_own", own, 0);
        chk("rst_async_busrq_n", busrq_n, 1);
        #2;
        reset = 1'b0;
        req = 4'b0110;
        step();
        busak_n = 1'b0;
        step();
        chk("rst_ptr_gnt", gnt, 4'b0010);
        chk("rst_ptr_owner", owner, 1);

`ifdef BUSARB_TIMEOUT_EN
        // Grant timeout with TIMEOUT_CYC=16 and request held.
        do_reset();
        cpu_auto = 1'b1;
        req = 4'b0001;
        wait_gnt(50);
        n = (gnt != 4'd0) ? 1 : 0;
        tev = 0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (tevt) tev++;
            if (gnt == 4'd0) break;
            n++;
        end
        chk("tmo_grant_len", n, 16);
        regrant = 0;
        repeat (40) begin
            step();
            if (tevt) tev++;
            if (gnt != 4'd0) regrant++;
        end
        chk("tmo_evt_count", tev, 1);
        chk("tmo_no_regrant", regrant, 0);
        req = 4'b0000;
        repeat (2) step();
        req = 4'b0001;
        wait_gnt(50);
        chk("tmo_regrant_after_toggle", gnt, 4'b0001);
`endif

        // MIN_CPU_CYC=0 instance: back-to-back tenures.
        do_reset();
        req0 = 4'b0001;
        step();
        chk("min0_busrq_lo", busrq0_n, 0);
        busak0_n = 1'b0;
        step();
        chk("min0_gnt", gnt0, 4'b0001);
        req0 = 4'b0000;
        step();
        chk("min0_release_busrq", busrq0_n, 1);
        chk("min0_release_gnt", gnt0, 0);
        step();
        chk("min0_wait_ak", busrq0_n, 1);
        req0 = 4'b0001;
        busak0_n = 1'b1;
        step();
        chk("min0_ak_rise", busrq0_n, 1);
        step();
        chk("min0_busrq_fall", busrq0_n, 0);
        busak0_n = 1'b0;
        step();
        chk("min0_regrant", gnt0, 4'b0001);
        chk("min0_timeout_evt", tevt0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
